sha2_block_feeder: RTL and testbench

//  Initiator side of the sha2_padding control interface. It accepts a message length in bits and a

---
 rtl/sha2_block_feeder_if.sv | 34 +++
 rtl/sha2_block_feeder.sv | 162 ++++++++++++++++
 tb/tb_sha2_block_feeder.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha2_block_feeder_if.sv
// Bundle of the feeder's stream, padding-control and core-buffer signals.
// master = the feeder itself, slave = the surrounding source/padding/core side.
interface sha2_block_feeder_if #(
  parameter int WIDTH = 32
) ();
  logic                 cmd_start;
  logic [2*WIDTH-1:0]   msg_len;
  logic [WIDTH-1:0]     s_data;
  logic                 s_valid;
  logic                 s_ready;
  logic [3:0]           pad_control;
  logic [4:0]           pad_ad;
  logic [WIDTH-1:0]     pad_data;
  logic [WIDTH-1:0]     pad_q;
  logic                 core_we;
  logic [3:0]           core_ad;
  logic [WIDTH-1:0]     core_wdata;
  logic                 core_start;
  logic                 core_done;
  logic                 busy;
  logic                 done;

  modport master (
    input  cmd_start, msg_len, s_data, s_valid, pad_q, core_done,
    output s_ready, pad_control, pad_ad, pad_data, core_we, core_ad,
           core_wdata, core_start, busy, done
  );

  modport slave (
    output cmd_start, msg_len, s_data, s_valid, pad_q, core_done,
    input  s_ready, pad_control, pad_ad, pad_data, core_we, core_ad,
           core_wdata, core_start, busy, done
  );
endinterface

// File: rtl/sha2_block_feeder.sv
// Drives the sha2_padding control port: programs the length, streams padded words
// into the SHA-2 core block buffer block by block, and sequences core starts.
module sha2_block_feeder #(
  parameter int WIDTH = 32,
  parameter int MODE  = 256
) (
  input  logic clk,
  input  logic rst,
  sha2_block_feeder_if.master bus
);

  localparam int BS  = (MODE == 224 || MODE == 256) ? 512 : 1024;
  localparam int LW  = 2 * WIDTH + 1;
  localparam int WSH = $clog2(WIDTH);
  localparam int BSH = $clog2(BS);

  typedef enum logic [3:0] {
    S_IDLE, S_LEN_H, S_LEN_L, S_BLOAD, S_FEED, S_ST1, S_ST2, S_WAIT, S_FIN
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         w_q, w_d;
  logic [LW-1:0]      blk_q, blk_d;
  logic [LW-1:0]      nw_q, nw_d;
  logic [LW-1:0]      nblk_q, nblk_d;
  logic [2*WIDTH-1:0] len_q, len_d;

  logic [LW-1:0]      len_ext;
  logic [LW-1:0]      nw_calc;
  logic [LW-1:0]      nblk_calc;
  logic [LW+3:0]      g_idx;
  logic               feed_msg;
  logic               advance;

  // Extra top bit keeps msg_len + 2*WIDTH from wrapping before the divide.
  assign len_ext   = {1'b0, bus.msg_len};
  assign nw_calc   = (len_ext + LW'(WIDTH - 1)) >> WSH;
  assign nblk_calc = ((len_ext + LW'(2 * WIDTH)) >> BSH) + LW'(1);

  assign g_idx    = {blk_q, w_q};
  assign feed_msg = g_idx < {4'b0000, nw_q};

  assign bus.core_wdata = bus.pad_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      w_q     <= '0;
      blk_q   <= '0;
      nw_q    <= '0;
      nblk_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      blk_q   <= blk_d;
      nw_q    <= nw_d;
      nblk_q  <= nblk_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    blk_d   = blk_q;
    nw_d    = nw_q;
    nblk_d  = nblk_q;
    len_d   = len_q;
    advance = 1'b0;

    bus.pad_control = 4'b0000;
    bus.pad_ad      = 5'd0;
    bus.pad_data    = '0;
    bus.s_ready     = 1'b0;
    bus.core_we     = 1'b0;
    bus.core_ad     = 4'd0;
    bus.core_start  = 1'b0;
    bus.busy        = 1'b1;
    bus.done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        bus.pad_control = 4'b0001;
        bus.busy        = 1'b0;
        if (bus.cmd_start) begin
          len_d   = bus.msg_len;
          nw_d    = nw_calc;
          nblk_d  = nblk_calc;
          blk_d   = '0;
          w_d     = '0;
          state_d = S_LEN_H;
        end
      end
      S_LEN_H: begin
        bus.pad_control = 4'b1000;
        bus.pad_data    = len_q[2*WIDTH-1:WIDTH];
        state_d         = S_LEN_L;
      end
      S_LEN_L: begin
        bus.pad_control = 4'b1000;
        bus.pad_ad      = 5'd1;
        bus.pad_data    = len_q[WIDTH-1:0];
        state_d         = S_BLOAD;
      end
      S_BLOAD: begin
        bus.pad_control = 4'b0010;
        w_d             = '0;
        state_d         = S_FEED;
      end
      // Past the end of the stream the padding unit fills in zeros, pad bit and length.
      S_FEED: begin
        bus.pad_ad  = {1'b0, w_q};
        bus.core_ad = w_q;
        if (feed_msg) begin
          bus.pad_data = bus.s_data;
          bus.s_ready  = 1'b1;
          advance      = bus.s_valid;
        end else begin
          advance = 1'b1;
        end
        if (advance) begin
          bus.core_we = 1'b1;
          if (w_q == 4'd15) begin
            state_d = S_ST1;
          end else begin
            w_d = w_q + 4'd1;
          end
        end
      end
      S_ST1: begin
        bus.pad_control = 4'b0100;
        state_d         = S_ST2;
      end
      S_ST2: begin
        bus.pad_control = 4'b0100;
        bus.core_start  = 1'b1;
        state_d         = S_WAIT;
      end
      S_WAIT: begin
        if (bus.core_done) begin
          if (blk_q == nblk_q - LW'(1)) begin
            state_d = S_FIN;
          end else begin
            blk_d   = blk_q + LW'(1);
            state_d = S_BLOAD;
          end
        end
      end
      S_FIN: begin
        bus.pad_control = 4'b0001;
        bus.busy        = 1'b0;
        bus.done        = 1'b1;
        state_d         = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sha2_block_feeder.sv
// Directed bench for sha2_block_feeder: behavioural padding unit and core buffer,
// each scenario task checks the blocks handed to the core against hand-computed words.
module tb_sha2_block_feeder;

  logic clk;
  logic rst;

  sha2_block_feeder_if #(.WIDTH(32)) bus ();

  sha2_block_feeder #(.WIDTH(32), .MODE(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] words [16];
  logic [31:0] blocks [4][16];
  int          nblk_seen;
  int          ready_seen;
  int          we_in_stall;
  int          stall_seen;

  // Behavioural padding unit: length register plus a start counter (2 per block).
  logic [63:0]     pm_len;
  int              pm_starts;
  longint unsigned pm_g, pm_base, pm_nb;
  logic [31:0]     pm_v;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pm_len    <= '0;
      pm_starts <= 0;
    end else if (bus.pad_control[0]) begin
      pm_len    <= '0;
      pm_starts <= 0;
    end else begin
      if (bus.pad_control[3]) begin
        if (bus.pad_ad == 5'd0) pm_len[63:32] <= bus.pad_data;
        else if (bus.pad_ad == 5'd1) pm_len[31:0] <= bus.pad_data;
      end
      if (bus.pad_control[2]) pm_starts <= pm_starts + 1;
    end
  end

  always_comb begin
    pm_g    = longint'(pm_starts / 2) * 16 + longint'(bus.pad_ad);
    pm_nb   = (pm_len + 64) / 512 + 1;
    pm_base = pm_g * 32;
    pm_v    = bus.pad_data;
    if (pm_len >= pm_base && pm_len < pm_base + 32)
      pm_v = pm_v | (32'h8000_0000 >> (pm_len - pm_base));
    if (pm_g == pm_nb * 16 - 2) pm_v = pm_len[63:32];
    else if (pm_g == pm_nb * 16 - 1) pm_v = pm_len[31:0];
    bus.pad_q = pm_v;
  end

  // Runs one message; acts as stream source and core model. abort_at>=0 pulls rst
  // low once that many words have been consumed and checks the reset outputs.
  task automatic run_msg(input logic [63:0] len, input int nw, input int stall_word,
                         input int stall_len, input int abort_at, input int dup_at,
                         output bit finished);
    int widx, stall_left, timer;
    logic [31:0] mem [16];
    bit stalling;
    finished = 1'b0; nblk_seen = 0; ready_seen = 0; we_in_stall = 0; stall_seen = 0;
    widx = 0; stall_left = stall_len; timer = 0;
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 16; i++) blocks[b][i] = 32'hDEAD_BEEF;
    for (int i = 0; i < 16; i++) mem[i] = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.cmd_start = 1'b1; bus.msg_len = len;
    @(negedge clk);
    bus.cmd_start = 1'b0; bus.msg_len = '0;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      bus.s_valid   = 1'b0;
      bus.s_data    = '0;
      bus.core_done = (timer == 1);
      if (timer > 0) timer--;
      bus.cmd_start = (cyc == dup_at);
      bus.msg_len   = (cyc == dup_at) ? 64'd512 : 64'd0;
      #1;
      stalling = (widx == stall_word) && (stall_left > 0) && bus.s_ready;
      if (stalling) begin
        stall_left--;
        stall_seen++;
      end else if (widx < nw) begin
        bus.s_valid = 1'b1;
        bus.s_data  = words[widx];
      end
      #1;
      if (abort_at >= 0 && widx == abort_at && bus.s_ready) begin
        rst = 1'b0;
        #1;
        total++;
        if (bus.pad_control !== 4'b0001 || bus.s_ready !== 1'b0 || bus.core_we !== 1'b0 ||
            bus.core_start !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.pad_ad !== 5'd0 || bus.pad_data !== 32'd0 || bus.core_ad !== 4'd0) begin
          bad++;
          $display("[TB] FAIL abort_outputs got pc=%b rdy=%b we=%b cs=%b busy=%b done=%b ad=%h data=%h cad=%h exp pc=0001 others 0",
                   bus.pad_control, bus.s_ready, bus.core_we, bus.core_start, bus.busy,
                   bus.done, bus.pad_ad, bus.pad_data, bus.core_ad);
        end
        bus.s_valid = 1'b0; bus.core_done = 1'b0; bus.cmd_start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      if (bus.s_ready) ready_seen++;
      if (stalling && bus.core_we) we_in_stall++;
      if (bus.core_we) mem[bus.core_ad] = bus.core_wdata;
      if (bus.core_start) begin
        if (nblk_seen < 4) blocks[nblk_seen] = mem;
        nblk_seen++;
        timer = 3;
      end
      if (bus.done) finished = 1'b1;
      if (bus.s_valid && bus.s_ready) widx++;
      @(negedge clk);
    end
    bus.s_valid = 1'b0; bus.core_done = 1'b0; bus.cmd_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.cmd_start = 1'b0; bus.msg_len = '0; bus.s_data = '0; bus.s_valid = 1'b0;
    bus.core_done = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (bus.pad_control !== 4'b0001) begin
      bad++; $display("[TB] FAIL reset_pad_control got=%b exp=0001", bus.pad_control);
    end
    total++;
    if ({bus.s_ready, bus.core_we, bus.core_start, bus.busy, bus.done} !== 5'b0) begin
      bad++; $display("[TB] FAIL reset_flags got=%b exp=00000",
                      {bus.s_ready, bus.core_we, bus.core_start, bus.busy, bus.done});
    end
    total++;
    if (bus.pad_ad !== 5'd0 || bus.pad_data !== 32'd0 || bus.core_ad !== 4'd0) begin
      bad++; $display("[TB] FAIL reset_addr got ad=%h data=%h cad=%h exp 0", bus.pad_ad,
                      bus.pad_data, bus.core_ad);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Shared expectation for the single-word "abc" message, used by several scenarios.
  task automatic check_abc(input string tag, input bit finished);
    logic [31:0] exp;
    total++;
    if (!finished) begin bad++; $display("[TB] FAIL %s_done got=0 exp=1", tag); end
    total++;
    if (nblk_seen !== 1) begin bad++; $display("[TB] FAIL %s_nblk got=%0d exp=1", tag, nblk_seen); end
    for (int i = 0; i < 16; i++) begin
      exp = (i == 0) ? 32'h6162_6380 : (i == 15) ? 32'h0000_0018 : 32'h0;
      total++;
      if (blocks[0][i] !== exp) begin
        bad++; $display("[TB] FAIL %s_w%0d got=%h exp=%h", tag, i, blocks[0][i], exp);
      end
    end
  endtask

  task automatic test_one_block();
    bit fin;
    words[0] = 32'h6162_6300;
    run_msg(64'd24, 1, -1, 0, -1, -1, fin);
    check_abc("abc", fin);
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL abc_busy_after got=%b exp=0", bus.busy); end
  endtask

  task automatic test_empty();
    bit fin;
    logic [31:0] exp;
    run_msg(64'd0, 0, -1, 0, -1, -1, fin);
    total++;
    if (!fin) begin bad++; $display("[TB] FAIL empty_done got=0 exp=1"); end
    total++;
    if (ready_seen !== 0) begin bad++; $display("[TB] FAIL empty_ready got=%0d exp=0", ready_seen); end
    total++;
    if (nblk_seen !== 1) begin bad++; $display("[TB] FAIL empty_nblk got=%0d exp=1", nblk_seen); end
    for (int i = 0; i < 16; i++) begin
      exp = (i == 0) ? 32'h8000_0000 : 32'h0;
      total++;
      if (blocks[0][i] !== exp) begin
        bad++; $display("[TB] FAIL empty_w%0d got=%h exp=%h", i, blocks[0][i], exp);
      end
    end
  endtask

  task automatic test_448();
    bit fin;
    logic [31:0] exp;
    for (int i = 0; i < 14; i++) words[i] = 32'hA500_0000 | 32'(i);
    run_msg(64'd448, 14, -1, 0, -1, -1, fin);
    total++;
    if (!fin || nblk_seen !== 2) begin
      bad++; $display("[TB] FAIL l448_nblk got=%0d done=%0d exp=2 done=1", nblk_seen, fin);
    end
    for (int i = 0; i < 16; i++) begin
      exp = (i < 14) ? (32'hA500_0000 | 32'(i)) : (i == 14) ? 32'h8000_0000 : 32'h0;
      total++;
      if (blocks[0][i] !== exp) begin
        bad++; $display("[TB] FAIL l448_b0w%0d got=%h exp=%h", i, blocks[0][i], exp);
      end
      exp = (i == 15) ? 32'h0000_01C0 : 32'h0;
      total++;
      if (blocks[1][i] !== exp) begin
        bad++; $display("[TB] FAIL l448_b1w%0d got=%h exp=%h", i, blocks[1][i], exp);
      end
    end
  endtask

  task automatic check_512(input string tag, input bit fin);
    logic [31:0] exp;
    total++;
    if (!fin || nblk_seen !== 2) begin
      bad++; $display("[TB] FAIL %s_nblk got=%0d done=%0d exp=2 done=1", tag, nblk_seen, fin);
    end
    for (int i = 0; i < 16; i++) begin
      exp = 32'h5A00_0000 | 32'(i);
      total++;
      if (blocks[0][i] !== exp) begin
        bad++; $display("[TB] FAIL %s_b0w%0d got=%h exp=%h", tag, i, blocks[0][i], exp);
      end
      exp = (i == 0) ? 32'h8000_0000 : (i == 15) ? 32'h0000_0200 : 32'h0;
      total++;
      if (blocks[1][i] !== exp) begin
        bad++; $display("[TB] FAIL %s_b1w%0d got=%h exp=%h", tag, i, blocks[1][i], exp);
      end
    end
  endtask

  task automatic test_512();
    bit fin;
    for (int i = 0; i < 16; i++) words[i] = 32'h5A00_0000 | 32'(i);
    run_msg(64'd512, 16, -1, 0, -1, -1, fin);
    check_512("l512", fin);
  endtask

  task automatic test_stall();
    bit fin;
    for (int i = 0; i < 16; i++) words[i] = 32'h5A00_0000 | 32'(i);
    run_msg(64'd512, 16, 3, 5, -1, -1, fin);
    total++;
    if (stall_seen !== 5) begin bad++; $display("[TB] FAIL stall_len got=%0d exp=5", stall_seen); end
    total++;
    if (we_in_stall !== 0) begin bad++; $display("[TB] FAIL stall_we got=%0d exp=0", we_in_stall); end
    check_512("stall", fin);
  endtask

  task automatic test_abort_restart();
    bit fin;
    for (int i = 0; i < 16; i++) words[i] = 32'h5A00_0000 | 32'(i);
    run_msg(64'd512, 16, -1, 0, 5, -1, fin);
    repeat (2) @(negedge clk);
    words[0] = 32'h6162_6300;
    run_msg(64'd24, 1, -1, 0, -1, 10, fin);
    check_abc("restart", fin);
  endtask

  initial begin
    test_reset();
    test_one_block();
    test_empty();
    test_448();
    test_512();
    test_stall();
    test_abort_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
